seq_sub: RTL and testbench
==========================

Name: seq_sub

Overview:
- Multi-cycle subtractor: computes diff = a - b - b_in over WIDTH bits, one 8-bit slice per clock, LSB slice first.
- Each slice uses an 8-bit carry-lookahead core in the subtract direction: a + ~b with carry-in = ~borrow.
- Provides a borrow-out, signed overflow and zero flags.
- Sits in the arithmetic datapath beside the 8-bit adders, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand and result width. Must be a multiple of 8 and at least 8.
- SLICES is derived as WIDTH/8; it is not a parameter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  minuend
- b  in  WIDTH  subtrahend
- b_in  in  1  borrow-in; 1 subtracts one extra
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- diff  out  WIDTH  a - b - b_in, modulo 2^WIDTH
- b_out  out  1  borrow-out; 1 when unsigned a < b + b_in
- ovf  out  1  signed two's-complement overflow
- zero  out  1  diff == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; slice counter = 0; internal borrow = 0.
  - out_valid = 0; diff = 0; b_out = 0; ovf = 0; zero = 0.
  - Handshake inputs are ignored while rst_n is low.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On the edge where in_valid & in_ready: latch a, b and b_in; set borrow = b_in and counter = 0; go to CALC.
- State CALC:
  - in_ready = 0, out_valid = 0.
  - Each edge processes slice k = counter:
    - {c8, s} = a[8k+7:8k] + ~b[8k+7:8k] + ~borrow, computed with carry lookahead.
    - diff[8k+7:8k] <= s; borrow <= ~c8; counter increments.
  - After the edge that processes slice SLICES-1, go to DONE.
- State DONE:
  - out_valid = 1, in_ready = 0.
  - b_out = final borrow.
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the latched a and b.
  - zero = (diff == 0).
  - diff, b_out, ovf and zero hold stable until out_valid & out_ready on an edge; then go to IDLE.
  - No same-cycle re-accept: the next operand is accepted at the earliest one cycle after the output handshake.
- Latency:
  - out_valid rises SLICES cycles after the accepting edge (4 for WIDTH=32).
  - Minimum initiation interval is SLICES+2 cycles.
- Output hold rules:
  - diff reflects partial slices during CALC and is valid only while out_valid = 1.
  - Flags register when DONE is entered and keep their last values in IDLE.
- Input changes:
  - Changes on a, b or b_in outside the accepting edge have no effect. Operands are latched.
  - in_valid high in CALC or DONE is not accepted. The producer holds the operands until in_ready.
- Wrap-around: the result is modulo 2^WIDTH; b_out reports the unsigned underflow.
- Reset mid-operation (CALC or DONE): the transaction is discarded and the state returns to IDLE immediately. No out_valid pulse occurs after reset release.
- out_ready is ignored outside DONE.

Test Plan (all cases WIDTH=32):
1. Basic subtract: a=0x00000005, b=0x00000003, b_in=0 -> out_valid 4 cycles after accept; diff=0x00000002, b_out=0, ovf=0, zero=0.
2. Underflow: a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, b_out=1, ovf=0.
   - Full borrow chain: a=0x01000000, b=0x00000001 -> diff=0x00FFFFFF, b_out=0.
3. Signed overflow: a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, b_out=0.
   - Second case: a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, b_out=1.
4. Zero and borrow-in:
   - a=b=0x12345678, b_in=0 -> diff=0, zero=1.
   - a=0x00000010, b=0x0000000F, b_in=1 -> diff=0, zero=1, b_out=0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1.
   - Outputs stay constant and in_ready=0 throughout.
   - out_ready=1 returns the block to IDLE; in_ready=1 on the next cycle; the pending operand is accepted on the following edge.
6. Reset mid-CALC: pull rst_n low after slice 1.
   - All outputs go to 0 asynchronously.
   - After release, in_ready=1 and out_valid never pulses for the aborted operands.
   - A new operand pair completes correctly.

Source files
------------

// File: rtl/seq_sub_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// The producer/consumer side uses master; the subtractor uses slave.
interface seq_sub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, ovf, zero
  );
endinterface

// File: rtl/seq_sub.sv
// Multi-cycle a - b - b_in, one 8-bit carry-lookahead slice per clock, LSB first; result after WIDTH/8 cycles.
// Backpressure: result and flags hold in DONE until out_ready; in_ready is high only in IDLE.
module seq_sub #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_sub_if.slave bus
);
  localparam int SLICES = WIDTH / 8;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
    $error("seq_sub: WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_nxt;
  logic             b_out_q, ovf_q, zero_q;
  logic [7:0]       a_slice, b_slice;
  logic [8:0]       sum;
  logic             last;

  // Flat sum-of-products carries: every carry depends only on g, p and cin.
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y, input logic cin);
    logic [7:0] g, p;
    logic [8:0] c;
    logic       t;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int k = j + 1; k <= i; k++) t = t & p[k];
        c[i+1] = c[i+1] | t;
      end
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  always_comb begin
    a_slice  = a_q[8*int'(cnt) +: 8];
    b_slice  = b_q[8*int'(cnt) +: 8];
    sum      = cla8(a_slice, ~b_slice, ~borrow);
    last     = (cnt == CW'(SLICES - 1));
    diff_nxt = diff_q;
    diff_nxt[8*int'(cnt) +: 8] = sum[7:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      borrow  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            borrow <= bus.b_in;
            cnt    <= '0;
          end
        end
        CALC: begin
          diff_q <= diff_nxt;
          borrow <= ~sum[8];
          cnt    <= cnt + 1'b1;
          // Flags are taken from the completed result on the final slice edge.
          if (last) begin
            b_out_q <= ~sum[8];
            ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[7] ^ a_q[WIDTH-1]);
            zero_q  <= (diff_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.b_out     = b_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_seq_sub.sv
// Directed bench for seq_sub (WIDTH=32) with an arithmetic reference model feeding a result queue.
module tb_seq_sub;
  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;
  res_t sb[$];
  res_t last;

  seq_sub_if #(.WIDTH(32)) bus ();
  seq_sub #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    res_t        r;
    logic [32:0] w;
    w    = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    r.d  = w[31:0];
    r.bo = w[32];
    r.ov = (a[31] != b[31]) && (w[31] != a[31]);
    r.z  = (w[31:0] == 32'h0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic rdy;
    logic acc;
    bus.a        = a;
    bus.b        = b;
    bus.b_in     = bin;
    bus.in_valid = 1'b1;
    acc          = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) acc = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    sb.push_back(model(a, b, bin));
  endtask

  task automatic expect_result(input string tag);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        got = 1'b1;
        n   = i;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'd4);
    if (sb.size() == 0) begin
      chk({tag, "_queue"}, 32'(sb.size()), 32'd1);
    end else begin
      last = sb.pop_front();
      chk({tag, "_diff"}, bus.diff, last.d);
      chk({tag, "_b_out"}, 32'(bus.b_out), 32'(last.bo));
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'(last.ov));
      chk({tag, "_zero"}, 32'(bus.zero), 32'(last.z));
    end
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    nvec          = 0;
    nerr          = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.b_in      = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_diff", bus.diff, 32'h0);
    chk("rst_b_out", 32'(bus.b_out), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(32'h00000005, 32'h00000003, 1'b0); expect_result("basic");     consume("basic");
    send(32'h00000000, 32'h00000001, 1'b0); expect_result("underflow"); consume("underflow");
    send(32'h01000000, 32'h00000001, 1'b0); expect_result("chain");     consume("chain");
    send(32'h80000000, 32'h00000001, 1'b0); expect_result("ovf_neg");   consume("ovf_neg");
    send(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0); expect_result("ovf_pos");   consume("ovf_pos");
    send(32'h12345678, 32'h12345678, 1'b0); expect_result("zero_eq");   consume("zero_eq");
    send(32'h00000010, 32'h0000000F, 1'b1); expect_result("zero_bin");  consume("zero_bin");
    send(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1); expect_result("mixed");     consume("mixed");

    // Backpressure: result held while a new operand waits on in_valid.
    send(32'h00001000, 32'h00000001, 1'b0);
    expect_result("bp_first");
    bus.a         = 32'h00000003;
    bus.b         = 32'h00000003;
    bus.b_in      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_diff", bus.diff, last.d);
      chk("bp_flags", {29'b0, bus.b_out, bus.ovf, bus.zero}, {29'b0, last.bo, last.ov, last.z});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_pending_accepted", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    sb.push_back(model(32'h00000003, 32'h00000003, 1'b0));
    expect_result("bp_second");
    consume("bp_second");

    // Reset after slice 1 of an operation.
    send(32'hDEADBEEF, 32'h01234567, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_diff", bus.diff, 32'h0);
    chk("mid_rst_b_out", 32'(bus.b_out), 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    chk("mid_rst_zero", 32'(bus.zero), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("post_rst_no_pulse", 32'(seen), 32'd0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(32'h00000100, 32'h00000001, 1'b0); expect_result("post_rst");  consume("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
